moisture_scan_controller: RTL
=============================

# moisture_scan_controller

Sequencer that time-shares one 8-bit soil-moisture ADC across NUM_CH probes. Per channel it drives the analog mux select, waits a settle time, issues conversions, averages 2^AVG_LOG2 samples and converts the average to a percentage. A hysteresis comparator then drives one pump enable per channel. It sits between the ADC front end and the irrigation actuators, replacing per-probe free-running sensor instances.

## Interface
- NUM_CH, 4, number of probes (2..16)
- AVG_LOG2, 2, log2 of samples averaged per channel (0..4)
- SETTLE_CYCLES, 8, clocks between ch_sel change and first adc_start (≥1)
- PERIOD_CYCLES, 1000, scan start-to-start period in clocks
- DRY_PCT, 30, pump turns on when pct < DRY_PCT
- WET_PCT, 60, pump turns off when pct ≥ WET_PCT (WET_PCT > DRY_PCT)
- TIMEOUT_CYCLES, 255, conversion watchdog (only with MOISTURE_TIMEOUT_EN)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; 0 = reset
- enable  in  1  scanning permitted
- adc_start  out  1  one-cycle conversion request
- adc_valid  in  1  one-cycle strobe, adc_data valid
- adc_data  in  8  raw conversion, higher = wetter
- ch_sel  out  $clog2(NUM_CH)  analog mux select
- moisture_valid  out  1  one-cycle strobe for the result fields
- moisture_ch  out  $clog2(NUM_CH)  channel of the published result
- moisture_pct  out  8  published percentage, 0..99
- pump_en  out  NUM_CH  per-channel pump drive
- scan_done  out  1  one-cycle pulse after last channel published
- timeout_err  out  NUM_CH  sticky per-channel conversion timeout

## Operation
- Reset values: every output is 0. FSM enters IDLE. Accumulator, sample counter, period counter and channel index are cleared.
- IDLE: pump_en is cleared. When enable = 1, go to SETTLE with ch = 0 and restart the period counter.
- SETTLE: ch_sel = ch. Count SETTLE_CYCLES, then go to START.
- START: assert adc_start for one cycle, then go to WAIT.
- WAIT: on adc_valid, add adc_data to the accumulator (width 8+AVG_LOG2) and increment the sample count.
  - If fewer than 2^AVG_LOG2 samples: go to START.
  - Otherwise: go to PUBLISH.
- PUBLISH, one cycle:
  - avg = acc >> AVG_LOG2 (truncating).
  - pct = (avg × 100) >> 8, using a 15-bit product.
  - Drive moisture_valid, moisture_ch and moisture_pct.
  - Hysteresis: pct < DRY_PCT sets pump_en[ch]; pct ≥ WET_PCT clears it; otherwise pump_en[ch] holds.
  - Clear the accumulator and sample count.
  - If ch = NUM_CH−1: pulse scan_done and go to HOLD.
  - Otherwise: ch+1, go to SETTLE.
- HOLD: wait until the period counter reaches PERIOD_CYCLES−1.
  - enable = 1: restart the period counter, go to SETTLE with ch = 0.
  - enable = 0: go to IDLE.
  - If the scan overran the period, leave HOLD on the next cycle. Overruns are not queued.
- enable is sampled only in IDLE and HOLD. Deasserting it mid-scan completes the scan first.
- adc_valid outside WAIT is ignored.

## Timing
- adc_start rises the cycle after ch_sel settles for SETTLE_CYCLES clocks.
- adc_valid is accepted from the cycle after adc_start; arbitrary latency.
- moisture_valid occurs exactly one cycle after the final adc_valid of the channel.
- Per-channel duration: SETTLE_CYCLES + 2^AVG_LOG2 × (1 + ADC latency) + 1.
- moisture_ch, moisture_pct and pump_en change only on the moisture_valid cycle. The result fields hold between strobes.
- Reset asserted in any state:
  - Returns to IDLE on the next edge.
  - Any in-flight conversion is abandoned.
  - A late adc_valid is ignored.

## Configuration
- MOISTURE_TIMEOUT_EN defined:
  - WAIT counts clocks since entering WAIT.
  - After TIMEOUT_CYCLES with no adc_valid:
    - timeout_err[ch] is set (sticky until reset).
    - pump_en[ch] is cleared.
    - No moisture_valid is issued for that channel.
    - The accumulator is cleared.
    - The FSM advances as if from PUBLISH, including scan_done for the last channel.
- Undefined: WAIT has no bound, and timeout_err is tied to 0.

## Structure
- Package moisture_pkg holds:
  - FSM state enum (IDLE, SETTLE, START, WAIT, PUBLISH, HOLD);
  - PCT_SCALE = 100 constant;
  - ADC_W = 8 localparam.
- One sub-module, moisture_hysteresis: a per-channel pump flag with DRY/WET compare, replicated NUM_CH times via generate, each with a load strobe.
- Sequencing, counters and averaging stay in the top level.

## Test plan
- NUM_CH=2, AVG_LOG2=2, 2-cycle ADC. ch0 samples 50,50,50,50 → pct 19, pump_en[0]=1. ch1 samples 200×4 → pct 78, pump_en[1]=0. scan_done follows ch1's moisture_valid by 1 cycle.
- Hysteresis: ch0 pump on, next scan avg 102 → pct 39, pump_en[0] holds 1. Then avg 154 → pct 60, pump_en[0]=0.
- Truncation: samples 10,11,12,13 → avg 11, pct 4. Avg 255 → pct 99.
- enable dropped during ch0 SETTLE → full scan completes, then IDLE and pump_en clears. Re-enable → scan restarts at ch0.
- reset low for 1 cycle while in WAIT → all outputs 0 next cycle. adc_valid arriving afterwards → no accumulation and no adc_start until enable.
- MOISTURE_TIMEOUT_EN, TIMEOUT_CYCLES=20, ch1 ADC never responds → timeout_err=2'b10, pump_en[1]=0, no moisture_valid for ch1, scan_done still pulses.

Source files
------------

// File: rtl/moisture_pkg.sv
// rtl/moisture_pkg.sv - shared states, constants and percentage helper for the moisture scanner
package moisture_pkg;

    localparam int ADC_W     = 8;
    localparam int PCT_SCALE = 100;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        PUBLISH,
        HOLD
    } state_t;

    // (avg * 100) >> 8 keeps the result in 0..99 for any 8-bit average
    function automatic logic [7:0] avg_to_pct(input logic [ADC_W-1:0] avg);
        logic [14:0] prod;
        prod = 15'(avg) * 15'(PCT_SCALE);
        return {1'b0, prod[14:8]};
    endfunction

endpackage

// File: rtl/moisture_hysteresis.sv
// rtl/moisture_hysteresis.sv - per-channel pump flag with dry/wet hysteresis
module moisture_hysteresis #(
    parameter int DRY_PCT = 30,
    parameter int WET_PCT = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic [7:0] pct,
    output logic       pump
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pump <= 1'b0;
        end else if (clear) begin
            pump <= 1'b0;
        end else if (load) begin
            if (pct < 8'(DRY_PCT)) begin
                pump <= 1'b1;
            end else if (pct >= 8'(WET_PCT)) begin
                pump <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/moisture_scan_controller.sv
// rtl/moisture_scan_controller.sv - shared-ADC moisture scanner with averaging and pump control; MOISTURE_TIMEOUT_EN adds a conversion watchdog
module moisture_scan_controller
    import moisture_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int PERIOD_CYCLES  = 1000,
    parameter int DRY_PCT        = 30,
    parameter int WET_PCT        = 60,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic                      adc_start,
    input  logic                      adc_valid,
    input  logic [ADC_W-1:0]          adc_data,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      moisture_valid,
    output logic [$clog2(NUM_CH)-1:0] moisture_ch,
    output logic [7:0]                moisture_pct,
    output logic [NUM_CH-1:0]         pump_en,
    output logic                      scan_done,
    output logic [NUM_CH-1:0]         timeout_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   ch;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [SMP_W-1:0]  smp_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic [PER_W-1:0]  period_cnt;
    logic [7:0]        new_pct;
    logic              last_ch;
    logic              last_smp;
    logic              period_done;
    logic              scan_start;
    logic              timeout_hit;

    assign acc_sum     = acc + ACC_W'(adc_data);
    assign new_pct     = avg_to_pct(acc_sum[ACC_W-1:AVG_LOG2]);
    assign last_ch     = (ch == CH_W'(NUM_CH - 1));
    assign last_smp    = (state == WAIT) && adc_valid && (smp_cnt == SMP_W'((1 << AVG_LOG2) - 1));
    assign period_done = (period_cnt == PER_W'(PERIOD_CYCLES - 1));
    assign scan_start  = enable && ((state == IDLE) || ((state == HOLD) && period_done));
    assign adc_start   = (state == START);
    assign ch_sel      = ch;

`ifdef MOISTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]   wait_cnt;
    logic [NUM_CH-1:0] timeout_q;

    assign timeout_hit = (state == WAIT) && !adc_valid && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_q <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_q[ch] <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err        = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SETTLE;
            SETTLE:  if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                if (adc_valid) begin
                    state_next = last_smp ? PUBLISH : START;
                end else if (timeout_hit) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: state_next = last_ch ? HOLD : SETTLE;
            HOLD:    if (period_done) state_next = enable ? SETTLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            ch             <= '0;
            acc            <= '0;
            smp_cnt        <= '0;
            settle_cnt     <= '0;
            period_cnt     <= '0;
            moisture_valid <= 1'b0;
            moisture_ch    <= '0;
            moisture_pct   <= '0;
            scan_done      <= 1'b0;
        end else begin
            state          <= state_next;
            moisture_valid <= 1'b0;
            scan_done      <= 1'b0;
            settle_cnt     <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;

            // Saturates so an overrun scan leaves HOLD on its first cycle
            if (scan_start) begin
                period_cnt <= '0;
            end else if (!period_done) begin
                period_cnt <= period_cnt + 1'b1;
            end

            if ((state == IDLE) || (state == HOLD)) begin
                ch <= '0;
            end else if ((state == PUBLISH) && !last_ch) begin
                ch <= ch + 1'b1;
            end

            if ((state == WAIT) && adc_valid) begin
                acc     <= acc_sum;
                smp_cnt <= smp_cnt + 1'b1;
            end

            // Result fields are loaded with the final sample so they are visible during PUBLISH
            if (last_smp) begin
                moisture_valid <= 1'b1;
                moisture_ch    <= ch;
                moisture_pct   <= new_pct;
            end

            if (state == PUBLISH) begin
                acc     <= '0;
                smp_cnt <= '0;
                if (last_ch) begin
                    scan_done <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pump
        moisture_hysteresis #(
            .DRY_PCT (DRY_PCT),
            .WET_PCT (WET_PCT)
        ) u_hyst (
            .clk   (clk),
            .reset (reset),
            .load  (last_smp && (ch == CH_W'(i))),
            .clear ((state == IDLE) || (timeout_hit && (ch == CH_W'(i)))),
            .pct   (new_pct),
            .pump  (pump_en[i])
        );
    end

endmodule
